// File: rtl/vga_frame_pkg.sv
// Shared constants and types for the VGA frame buffer: frame geometry, writer FSM
// state encoding and small sizing helpers used by the writer and the reader.
package vga_frame_pkg;

    localparam int VGA_H_PIXELS        = 480;
    localparam int VGA_V_PIXELS        = 360;
    localparam int VGA_BPP             = 24;
    localparam int VGA_WORD_BITS       = 32;
    localparam int DEFAULT_FRAME_WORDS = VGA_H_PIXELS * VGA_V_PIXELS * VGA_BPP / VGA_WORD_BITS;

    typedef enum logic [1:0] {
        WR_IDLE   = 2'd0,
        WR_FILL   = 2'd1,
        WR_COMMIT = 2'd2
    } wr_state_e;

    localparam logic [1:0] ST_IDLE   = WR_IDLE;
    localparam logic [1:0] ST_FILL   = WR_FILL;
    localparam logic [1:0] ST_COMMIT = WR_COMMIT;

    // Width of a counter indexing n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Shifts received bytes into a word, first byte ending up in the MSBs; flags the
// byte that completes a word so the caller can register it.
module byte_packer
    import vga_frame_pkg::*;
#(
    parameter  int RAM_WIDTH = 32,
    localparam int BPW       = RAM_WIDTH / 8,
    localparam int CW        = idx_width(BPW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [7:0]           byte_data,
    input  logic                 byte_valid,
    output logic [RAM_WIDTH-1:0] word,
    output logic                 word_valid,
    output logic [CW-1:0]        byte_cnt
);

    logic [RAM_WIDTH-1:0] acc;
    logic [RAM_WIDTH+7:0] shifted;
    logic                 last_byte;

    // Concatenating one byte past the top keeps this correct even for BPW == 1.
    assign shifted    = {acc, byte_data};
    assign word       = shifted[RAM_WIDTH-1:0];
    assign last_byte  = (byte_cnt == CW'(BPW - 1));
    assign word_valid = byte_valid && last_byte && !clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc      <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            acc      <= '0;
            byte_cnt <= '0;
        end else if (byte_valid) begin
            acc      <= word;
            byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_writer.sv
// Packs a UART byte stream into frame-buffer words and writes them to sequential
// RAM addresses, wrapping per frame. Optional inter-byte timeout resync: FRAME_TIMEOUT_EN.
module serial_frame_writer
    import vga_frame_pkg::*;
#(
    parameter  int RAM_WIDTH      = 32,
    parameter  int FRAME_WORDS    = DEFAULT_FRAME_WORDS,
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int AW             = idx_width(FRAME_WORDS),
    localparam int BPW            = RAM_WIDTH / 8,
    localparam int CW             = idx_width(BPW)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic [RAM_WIDTH-1:0] wr_data,
    output logic                 frame_done,
    output logic                 sync_lost,
    output logic [1:0]           dbg_state
);

    // Handshake: rx_valid is a one-cycle strobe with no backpressure; every strobe is
    // consumed on the clock edge it is seen, and wr_en likewise presents one word per pulse.

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [AW-1:0]        addr_cnt;
    logic                 addr_last;
    logic [RAM_WIDTH-1:0] word;
    logic                 word_valid;
    logic [CW-1:0]        byte_cnt;
    logic                 resync;

    assign dbg_state = state;
    assign addr_last = (addr_cnt == AW'(FRAME_WORDS - 1));

    byte_packer #(
        .RAM_WIDTH (RAM_WIDTH)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (resync),
        .byte_data  (rx_data),
        .byte_valid (rx_valid),
        .word       (word),
        .word_valid (word_valid),
        .byte_cnt   (byte_cnt)
    );

`ifdef FRAME_TIMEOUT_EN
    localparam int TW = idx_width(TIMEOUT_CYCLES);

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    assign to_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    // An idle line with nothing buffered and the address at 0 is already in sync.
    assign resync = to_hit && !rx_valid && ((byte_cnt != '0) || (addr_cnt != '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            sync_lost <= 1'b0;
        end else begin
            sync_lost <= resync;
            if (rx_valid || resync) begin
                to_cnt <= '0;
            end else if (!to_hit) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign resync    = 1'b0;
    assign sync_lost = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (word_valid) begin
                    state_next = ST_COMMIT;
                end else if (rx_valid) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (word_valid) begin
                    state_next = ST_COMMIT;
                end else if (!rx_valid && (byte_cnt == '0)) begin
                    state_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (word_valid) begin
                    state_next = ST_COMMIT;
                end else if (rx_valid) begin
                    state_next = ST_FILL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (resync) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // addr_cnt is the next address to use, so wr_addr holds steady between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            frame_done <= 1'b0;
            addr_cnt   <= '0;
        end else begin
            wr_en      <= word_valid;
            frame_done <= word_valid && addr_last;
            if (resync) begin
                addr_cnt <= '0;
                wr_addr  <= '0;
            end else if (word_valid) begin
                wr_data  <= word;
                wr_addr  <= addr_cnt;
                addr_cnt <= addr_last ? '0 : addr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_writer.sv
// Directed bench for serial_frame_writer with a write scoreboard; the timeout
// scenario adapts to whether FRAME_TIMEOUT_EN is defined.
module tb_serial_frame_writer;
    import vga_frame_pkg::*;

    localparam int RAM_WIDTH      = 32;
    localparam int FRAME_WORDS    = 4;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int AW             = 2;
    localparam int BPW            = RAM_WIDTH / 8;
    localparam int EW             = 32 + 1 + AW + RAM_WIDTH;

    logic                 clk;
    logic                 rst;
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [RAM_WIDTH-1:0] wr_data;
    logic                 frame_done;
    logic                 sync_lost;
    logic [1:0]           dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_sync  = 0;
    int seen_sync = 0;

    // Expected write: {cycle seen, frame_done, wr_addr, wr_data}
    logic [EW-1:0] exp_q[$];

    logic [RAM_WIDTH-1:0] m_acc;
    int                   m_cnt;
    int                   m_addr;

    serial_frame_writer #(
        .RAM_WIDTH      (RAM_WIDTH),
        .FRAME_WORDS    (FRAME_WORDS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .sync_lost  (sync_lost),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // ---------------- helpers / drivers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_acc  = '0;
        m_cnt  = 0;
        m_addr = 0;
    endtask

    // Called on a negedge; leaves time at the next negedge with rx_valid low.
    task automatic send_byte(input logic [7:0] b);
        logic [EW-1:0] e;
        rx_data  = b;
        rx_valid = 1'b1;
        m_acc    = {m_acc[RAM_WIDTH-9:0], b};
        m_cnt++;
        if (m_cnt == BPW) begin
            e = {32'(cyc + 1), (m_addr == FRAME_WORDS - 1), AW'(m_addr), m_acc};
            exp_q.push_back(e);
            m_cnt  = 0;
            m_addr = (m_addr == FRAME_WORDS - 1) ? 0 : m_addr + 1;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("async_reset_state", 64'(dbg_state), 64'(ST_IDLE));
        check("async_reset_wr_en", 64'(wr_en), 64'd0);
        idle(2);
        rst = 1'b1;
        model_clear();
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sync_lost) seen_sync++;
                if (frame_done && !wr_en) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_done_without_write at cycle %0d", cyc);
                end
                if (wr_en) begin
                    n_tests++;
                    a = {32'(cyc), frame_done, wr_addr, wr_data};
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_write: cycle %0d addr %0d data 0x%08h", cyc, wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            n_fail++;
                            $display("FAIL write: got cyc %0d fd %0b addr %0d data 0x%08h, expected cyc %0d fd %0b addr %0d data 0x%08h",
                                     a[EW-1 -: 32], a[AW+RAM_WIDTH], a[AW+RAM_WIDTH-1 -: AW], a[RAM_WIDTH-1:0],
                                     e[EW-1 -: 32], e[AW+RAM_WIDTH], e[AW+RAM_WIDTH-1 -: AW], e[RAM_WIDTH-1:0]);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_clear();
        idle(3);
        check("reset_wr_en",      64'(wr_en),      64'd0);
        check("reset_wr_addr",    64'(wr_addr),    64'd0);
        check("reset_wr_data",    64'(wr_data),    64'd0);
        check("reset_frame_done", 64'(frame_done), 64'd0);
        check("reset_sync_lost",  64'(sync_lost),  64'd0);
        check("reset_state",      64'(dbg_state),  64'(ST_IDLE));
        rst = 1'b1;
        idle(2);

        // Spaced bytes -> 0x11223344 at address 0
        send_byte(8'h11);
        check("state_fill_after_first", 64'(dbg_state), 64'(ST_FILL));
        idle(3);
        send_byte(8'h22); idle(3);
        send_byte(8'h33); idle(3);
        send_byte(8'h44);
        idle(3);
        check("wr_data_holds", 64'(wr_data), 64'h11223344);

        // Eight back-to-back bytes -> addresses 1 and 2, four cycles apart
        send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
        send_byte(8'h89); send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
        idle(3);

        // Fresh frame: 16 back-to-back bytes fill the frame, then wrap to 0
        do_reset();
        idle(1);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(8'h30 + i * 7));
        end
        idle(3);

        // Reset discards a partial word
        send_byte(8'h5A);
        send_byte(8'hA5);
        do_reset();
        idle(1);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        idle(3);
        check("post_reset_word", 64'(wr_data), 64'hAABBCCDD);

        // Idle gap after a partial word
        do_reset();
        idle(1);
        send_byte(8'h12);
        send_byte(8'h34);
        idle(20);
`ifdef FRAME_TIMEOUT_EN
        exp_sync++;
        model_clear();
        check("state_after_timeout", 64'(dbg_state), 64'(ST_IDLE));
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
`else
        check("state_after_gap", 64'(dbg_state), 64'(ST_FILL));
        send_byte(8'h56); send_byte(8'h78);
`endif
        idle(4);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("sync_lost_pulses",   64'(seen_sync),    64'(exp_sync));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
